// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector with valid/ready flow control, frame resync
// and row/frame markers. One registered result beat per accepted input pixel.
module sobel_edge_stream #(
  parameter int IMG_WIDTH  = 256,
  parameter int IMG_HEIGHT = 256,
  parameter int DATA_WIDTH = 8,
  parameter int MAG_WIDTH  = DATA_WIDTH + 3,
  parameter int MODE       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_pixel,
  input  logic                  in_sof,
  input  logic [MAG_WIDTH-1:0]  threshold,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [MAG_WIDTH-1:0]  out_mag,
  output logic                  out_edge,
  output logic                  out_interior,
  output logic                  out_eol,
  output logic                  out_eof
);

  localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam int SUM_W = DATA_WIDTH + 4;

  typedef logic signed [SUM_W-1:0] sum_t;
  typedef logic [2:0][DATA_WIDTH-1:0] column_t;

  function automatic sum_t widen(input logic [DATA_WIDTH-1:0] p);
    return sum_t'({4'b0000, p});
  endfunction

  function automatic logic [MAG_WIDTH-1:0] abs_mag(input sum_t v);
    sum_t a;
    a = (v < 0) ? -v : v;
    return MAG_WIDTH'(a);
  endfunction

  logic [COL_W-1:0]      col_q, col_d, cur_col;
  logic [ROW_W-1:0]      row_q, row_d, cur_row;
  column_t               win_l_q, win_l_d, win_m_q, win_m_d, col_c;
  logic                  out_valid_q, out_valid_d;
  logic [MAG_WIDTH-1:0]  out_mag_q, out_mag_d;
  logic                  out_edge_q, out_edge_d;
  logic                  out_interior_q, out_interior_d;
  logic                  out_eol_q, out_eol_d;
  logic                  out_eof_q, out_eof_d;

  logic [DATA_WIDTH-1:0] lb_r1_mem [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] lb_r2_mem [IMG_WIDTH];

  logic                  accept;
  logic                  interior;
  logic                  last_col;
  logic                  last_row;
  sum_t                  gx, gy;
  logic [MAG_WIDTH-1:0]  mag;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    cur_col  = in_sof ? '0 : col_q;
    cur_row  = in_sof ? '0 : row_q;
    last_col = (cur_col == COL_W'(IMG_WIDTH - 1));
    last_row = (cur_row == ROW_W'(IMG_HEIGHT - 1));
    interior = (cur_row >= ROW_W'(2)) && (cur_col >= COL_W'(2));

    // Column c of the window: rows r-2, r-1 from the line buffers, row r live.
    col_c[0] = lb_r2_mem[cur_col];
    col_c[1] = lb_r1_mem[cur_col];
    col_c[2] = in_pixel;

    gx = (widen(col_c[0]) + (widen(col_c[1]) <<< 1) + widen(col_c[2]))
       - (widen(win_l_q[0]) + (widen(win_l_q[1]) <<< 1) + widen(win_l_q[2]));
    gy = (widen(win_l_q[2]) + (widen(win_m_q[2]) <<< 1) + widen(col_c[2]))
       - (widen(win_l_q[0]) + (widen(win_m_q[0]) <<< 1) + widen(col_c[0]));
    mag = abs_mag(gx) + abs_mag(gy);

    col_d          = col_q;
    row_d          = row_q;
    win_l_d        = win_l_q;
    win_m_d        = win_m_q;
    out_valid_d    = out_valid_q;
    out_mag_d      = out_mag_q;
    out_edge_d     = out_edge_q;
    out_interior_d = out_interior_q;
    out_eol_d      = out_eol_q;
    out_eof_d      = out_eof_q;

    if (accept) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : cur_row + ROW_W'(1);
      end else begin
        col_d = cur_col + COL_W'(1);
        row_d = cur_row;
      end
      win_l_d        = win_m_q;
      win_m_d        = col_c;
      out_valid_d    = 1'b1;
      out_mag_d      = interior ? mag : '0;
      out_edge_d     = (MODE == 1) && interior && (mag >= threshold);
      out_interior_d = interior;
      out_eol_d      = last_col;
      out_eof_d      = last_col && last_row;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q          <= '0;
      row_q          <= '0;
      win_l_q        <= '0;
      win_m_q        <= '0;
      out_valid_q    <= 1'b0;
      out_mag_q      <= '0;
      out_edge_q     <= 1'b0;
      out_interior_q <= 1'b0;
      out_eol_q      <= 1'b0;
      out_eof_q      <= 1'b0;
    end else begin
      col_q          <= col_d;
      row_q          <= row_d;
      win_l_q        <= win_l_d;
      win_m_q        <= win_m_d;
      out_valid_q    <= out_valid_d;
      out_mag_q      <= out_mag_d;
      out_edge_q     <= out_edge_d;
      out_interior_q <= out_interior_d;
      out_eol_q      <= out_eol_d;
      out_eof_q      <= out_eof_d;
    end
  end

  // Line-buffer RAM carries no reset; stale rows only ever feed non-interior windows.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb_r2_mem[cur_col] <= lb_r1_mem[cur_col];
      lb_r1_mem[cur_col] <= in_pixel;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_mag      = out_mag_q;
  assign out_edge     = out_edge_q;
  assign out_interior = out_interior_q;
  assign out_eol      = out_eol_q;
  assign out_eof      = out_eof_q;

endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Parametrised, streaming 3x3 Sobel edge detector; second generation of the team's Sobel filter.
- Adds over the first generation:
  - configurable image size and pixel width;
  - valid/ready backpressure;
  - start-of-frame resync;
  - row and frame markers;
  - optional threshold (binary edge) mode.
- Sits between the pixel source (camera/DMA unpacker) and the edge-map writer.
- Produces exactly one output beat per accepted input pixel.

Parameters:
- IMG_WIDTH, 256, pixels per row (>=4).
- IMG_HEIGHT, 256, rows per frame (>=3).
- DATA_WIDTH, 8, bits per input pixel.
- MAG_WIDTH, DATA_WIDTH+3, output magnitude width; holds 8*(2^DATA_WIDTH-1) without overflow.
- MODE, 0, 0 = magnitude output; 1 = threshold output (out_edge meaningful, out_mag still driven).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present on in_pixel.
- in_ready  out  1  block can accept; combinational, = !out_valid || out_ready.
- in_pixel  in  DATA_WIDTH  unsigned pixel, raster order.
- in_sof  in  1  qualifies the accepted pixel as frame position (0,0).
- threshold  in  MAG_WIDTH  edge threshold; sampled at each accept.
- out_valid  out  1  result beat present.
- out_ready  in  1  downstream accepts beat.
- out_mag  out  MAG_WIDTH  |gx|+|gy| for interior windows, else 0.
- out_edge  out  1  MODE=1: interior && mag >= threshold; MODE=0: tied 0.
- out_interior  out  1  window fully inside the current frame.
- out_eol  out  1  beat belongs to column IMG_WIDTH-1.
- out_eof  out  1  beat belongs to pixel (IMG_HEIGHT-1, IMG_WIDTH-1).

Behaviour:
- Accept when in_valid && in_ready.
- Reset (rst=0, async): out_valid, out_mag, out_edge, out_interior, out_eol and out_eof go to 0; col/row counters, line-buffer index and window registers go to 0. Line-buffer RAM is not cleared. Reset mid-frame discards the frame; the next accepted pixel is (0,0).
- Position:
  - col/row counters advance on accept only.
  - col wraps at IMG_WIDTH-1 and increments row; row wraps at IMG_HEIGHT-1 to 0.
  - Accept with in_sof=1 treats that pixel as (0,0) regardless of counters; counters then continue from (0,1).
- Line buffers:
  - two IMG_WIDTH-deep buffers (rows r-1, r-2) indexed by col; read and write at the same index on accept.
  - r-2 entry <= r-1 entry; r-1 entry <= in_pixel.
- Window:
  - the accepted pixel at (r,c) completes the 3x3 window of rows r-2..r and columns c-2..c, centre (r-1,c-1).
  - Columns c-2 and c-1 come from 3x2 shift registers advanced on accept; column c comes from {buffer r-2, buffer r-1, in_pixel} combinationally.
- Arithmetic:
  - signed, width DATA_WIDTH+4.
  - gx = (tr + 2mr + br) - (tl + 2ml + bl).
  - gy = (bl + 2bc + br) - (tl + 2tc + tr).
  - mag = |gx| + |gy|, unsigned MAG_WIDTH, no saturation needed.
- Interior = (r >= 2) && (c >= 2); windows never straddle rows or frames. Non-interior beats: out_mag=0, out_edge=0, out_interior=0.
- Latency: result registered on accept; out_valid rises the cycle after accept.
- Handshake:
  - out_valid stays high, and all out_* stay stable, until out_ready=1.
  - Simultaneous accept and drain replaces the beat with no bubble, giving full throughput at out_ready=1.
  - Drain with no accept clears out_valid.
  - out_ready=0 with out_valid=1 forces in_ready=0; no input is lost or duplicated, and window/counters hold.
- threshold changes take effect on the next accepted pixel only.
- out_eol and out_eof are tags of the accepted pixel's position, independent of out_interior.

Test Plan:
- W=8,H=6,D=8, MODE=0; flat frame of 100, out_ready=1 → 48 beats; all out_mag=0; out_interior=1 on 24 beats (r>=2,c>=2); out_eol on every 8th beat; out_eof on beat 48 only.
- Vertical step: cols 0-3=0, cols 4-7=255 → interior beats at c=4 and c=5 give out_mag=1020; c=2,3,6,7 give 0.
- Window 0,0,255 / 0,255,255 / 255,255,255 (rows top..bottom) at an interior position → gx=765, gy=765, out_mag=1530. Checks MAG_WIDTH=11 carries with no wrap.
- Backpressure: random out_ready (50%) and random in_valid over 3 frames → output stream matches the golden model beat-for-beat; out_* never change while out_valid && !out_ready.
- MODE=1, threshold=1020, step image above → out_edge=1 at c=4 and c=5 only. Same image with threshold=1021 gives out_edge=0 on every beat.
- in_sof asserted at row 3 col 5 → that beat is non-interior, counters restart; following beats match a fresh frame. rst pulsed low mid-row → out_valid=0 immediately (async), and the next frame decodes correctly from (0,0).
